// File: rtl/health_score_accumulator_pkg.sv
// Shared types and widths for the health score accumulator.
// Optional saturation is enabled with HEALTH_ACC_SATURATE_EN (see top level).
package health_score_accumulator_pkg;

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned SUM_W   = 8;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD_LO = 2'd1,
        ADD_HI = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/health_score_accumulator_nibble_adder.sv
// 4-bit adder with carry-in and carry-out, shared between both accumulator nibbles.
module nibble_adder
    import health_score_accumulator_pkg::*;
(
    input  logic [SCORE_W-1:0] i_a,
    input  logic [SCORE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SCORE_W-1:0] o_sum,
    output logic               o_cout
);

    logic [SCORE_W:0] w_full;

    assign w_full = (SCORE_W+1)'(i_a) + (SCORE_W+1)'(i_b) + (SCORE_W+1)'(i_cin);
    assign o_sum  = w_full[SCORE_W-1:0];
    assign o_cout = w_full[SCORE_W];

endmodule

// File: rtl/health_score_accumulator.sv
// Accumulates WINDOW 4-bit scores nibble-serially and reports total plus threshold alarm.
// Define HEALTH_ACC_SATURATE_EN to clamp an overflowing window total to 8'hFF.
module health_score_accumulator
    import health_score_accumulator_pkg::*;
#(
    parameter int unsigned WINDOW    = 8,
    parameter int unsigned THRESHOLD = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [SCORE_W-1:0] in_score,
    output logic               in_ready,
    output logic               out_valid,
    output logic [SUM_W-1:0]   out_sum,
    output logic               out_alarm,
    input  logic               out_ready
);

    state_t               r_state;
    logic [SUM_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_count;
    logic                 r_carry;
    logic [SCORE_W-1:0]   r_operand;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [SUM_W-1:0]     r_out_sum;
    logic                 r_out_alarm;
`ifdef HEALTH_ACC_SATURATE_EN
    logic                 r_ovf;
`endif

    logic                 w_hi;
    logic [SCORE_W-1:0]   w_a;
    logic [SCORE_W-1:0]   w_b;
    logic                 w_cin;
    logic [SCORE_W-1:0]   w_sum;
    logic                 w_cout;
    logic [CNT_W-1:0]     w_count_inc;

    // One adder: low nibble + operand, then high nibble + registered carry.
    assign w_hi        = (r_state == ADD_HI);
    assign w_a         = w_hi ? r_acc[SUM_W-1:SCORE_W] : r_acc[SCORE_W-1:0];
    assign w_b         = w_hi ? '0 : r_operand;
    assign w_cin       = w_hi ? r_carry : 1'b0;
    assign w_count_inc = r_count + CNT_W'(1);

    nibble_adder u_nibble_adder (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_operand   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_alarm <= 1'b0;
`ifdef HEALTH_ACC_SATURATE_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_operand  <= in_score;
                        r_in_ready <= 1'b0;
                        r_state    <= ADD_LO;
                    end
                end
                ADD_LO: begin
`ifdef HEALTH_ACC_SATURATE_EN
                    if (!r_ovf) r_acc[SCORE_W-1:0] <= w_sum;
`else
                    r_acc[SCORE_W-1:0] <= w_sum;
`endif
                    r_carry <= w_cout;
                    r_state <= ADD_HI;
                end
                ADD_HI: begin
                    r_acc[SUM_W-1:SCORE_W] <= w_sum;
`ifdef HEALTH_ACC_SATURATE_EN
                    if (w_cout || r_ovf) begin
                        r_acc <= '1;
                        r_ovf <= 1'b1;
                    end
`endif
                    r_carry <= 1'b0;
                    r_count <= w_count_inc;
                    if (w_count_inc == CNT_W'(WINDOW)) begin
                        r_state <= DONE;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                DONE: begin
                    // First DONE cycle captures the report; it then holds until accepted.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_sum   <= r_acc;
                        r_out_alarm <= (r_acc > SUM_W'(THRESHOLD));
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_carry     <= 1'b0;
`ifdef HEALTH_ACC_SATURATE_EN
                        r_ovf       <= 1'b0;
`endif
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_alarm = r_out_alarm;

endmodule

// File: tb/tb_health_score_accumulator.sv
// Directed bench for health_score_accumulator across several WINDOW settings.
module tb_health_score_accumulator;

    localparam int NDUT = 4;

    logic       clk = 1'b0;
    logic       rst_n     [NDUT];
    logic       in_valid  [NDUT];
    logic [3:0] in_score  [NDUT];
    logic       in_ready  [NDUT];
    logic       out_valid [NDUT];
    logic [7:0] out_sum   [NDUT];
    logic       out_alarm [NDUT];
    logic       out_ready [NDUT];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Windows: dut0=2, dut1=4, dut2=20, dut3=1; threshold 40 everywhere.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        health_score_accumulator #(
            .WINDOW    (g == 0 ? 2 : (g == 1 ? 4 : (g == 2 ? 20 : 1))),
            .THRESHOLD (40)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .in_valid  (in_valid[g]),
            .in_score  (in_score[g]),
            .in_ready  (in_ready[g]),
            .out_valid (out_valid[g]),
            .out_sum   (out_sum[g]),
            .out_alarm (out_alarm[g]),
            .out_ready (out_ready[g])
        );
    end

    typedef struct {
        int          k;
        int          n;
        logic [15:0] sc;
        logic [7:0]  sum;
        logic        alarm;
    } vec_t;

    vec_t vt[8];

    function automatic logic [15:0] p4(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic [3:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [3:0] s);
        int n;
        n = 0;
        while (!in_ready[k] && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready[k]) chk("send_timeout", k, 32'(in_ready[k]), 32'd1);
        in_valid[k] = 1'b1;
        in_score[k] = s;
        tick();
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_report(input int k, output int lat);
        lat = 0;
        while (!out_valid[k] && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_report(input int k);
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        chk("release_valid", k, 32'(out_valid[k]), 32'd0);
        chk("release_ready", k, 32'(in_ready[k]), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag, input int k);
        chk({tag, "_in_ready"},  k, 32'(in_ready[k]),  32'd1);
        chk({tag, "_out_valid"}, k, 32'(out_valid[k]), 32'd0);
        chk({tag, "_out_sum"},   k, 32'(out_sum[k]),   32'd0);
        chk({tag, "_out_alarm"}, k, 32'(out_alarm[k]), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [15:0] tmp;

        vt[0] = '{0, 2, p4(4'd9,  4'd8,  4'd0,  4'd0),  8'd17, 1'b0};
        vt[1] = '{0, 2, p4(4'd15, 4'd15, 4'd0,  4'd0),  8'd30, 1'b0};
        vt[2] = '{0, 2, p4(4'd0,  4'd0,  4'd0,  4'd0),  8'd0,  1'b0};
        vt[3] = '{1, 4, p4(4'd15, 4'd15, 4'd15, 4'd15), 8'd60, 1'b1};
        vt[4] = '{1, 4, p4(4'd10, 4'd10, 4'd10, 4'd10), 8'd40, 1'b0};
        vt[5] = '{1, 4, p4(4'd10, 4'd10, 4'd10, 4'd11), 8'd41, 1'b1};
        vt[6] = '{3, 1, p4(4'd7,  4'd0,  4'd0,  4'd0),  8'd7,  1'b0};
        vt[7] = '{3, 1, p4(4'd15, 4'd0,  4'd0,  4'd0),  8'd15, 1'b0};

        for (int k = 0; k < NDUT; k++) begin
            rst_n[k]     = 1'b0;
            in_valid[k]  = 1'b0;
            in_score[k]  = 4'd0;
            out_ready[k] = 1'b0;
        end
        tick();
        tick();
        for (int k = 0; k < NDUT; k++) check_reset_vals("reset", k);
        for (int k = 0; k < NDUT; k++) rst_n[k] = 1'b1;

        // Idle hold, with out_ready asserted outside DONE on dut0.
        out_ready[0] = 1'b1;
        repeat (4) tick();
        out_ready[0] = 1'b0;
        for (int k = 0; k < NDUT; k++) check_reset_vals("idle", k);

        // Table-driven windows with latency, sum, alarm and release checks.
        for (int i = 0; i < 8; i++) begin
            tmp = vt[i].sc;
            for (int j = 0; j < vt[i].n; j++) send(vt[i].k, tmp[4*j +: 4]);
            wait_report(vt[i].k, lat);
            chk($sformatf("latency_v%0d", i), vt[i].k, 32'(lat), 32'd3);
            chk($sformatf("sum_v%0d", i),     vt[i].k, 32'(out_sum[vt[i].k]),   32'(vt[i].sum));
            chk($sformatf("alarm_v%0d", i),   vt[i].k, 32'(out_alarm[vt[i].k]), 32'(vt[i].alarm));
            release_report(vt[i].k);
        end

        // Backpressure: report held for 10 cycles while upstream offers a sample.
        for (int j = 0; j < 4; j++) send(1, 4'd5);
        wait_report(1, lat);
        in_valid[1] = 1'b1;
        in_score[1] = 4'd15;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_valid", 1, 32'(out_valid[1]), 32'd1);
            chk("bp_sum",   1, 32'(out_sum[1]),   32'd20);
            chk("bp_alarm", 1, 32'(out_alarm[1]), 32'd0);
            chk("bp_ready", 1, 32'(in_ready[1]),  32'd0);
        end
        in_valid[1] = 1'b0;
        release_report(1);
        for (int j = 0; j < 4; j++) send(1, 4'd1);
        wait_report(1, lat);
        chk("post_bp_sum", 1, 32'(out_sum[1]), 32'd4);
        release_report(1);

        // Reset during ADD_HI of the third sample discards the partial window.
        send(1, 4'd1);
        send(1, 4'd2);
        send(1, 4'd3);
        tick();
        rst_n[1] = 1'b0;
        #1;
        check_reset_vals("midreset", 1);
        #1;
        rst_n[1] = 1'b1;
        send(1, 4'd2);
        send(1, 4'd3);
        send(1, 4'd4);
        send(1, 4'd5);
        wait_report(1, lat);
        chk("midreset_latency", 1, 32'(lat), 32'd3);
        chk("midreset_sum",     1, 32'(out_sum[1]),   32'd14);
        chk("midreset_alarm",   1, 32'(out_alarm[1]), 32'd0);
        release_report(1);

        // Overflow: twenty scores of 15 total 300.
        for (int j = 0; j < 20; j++) send(2, 4'd15);
        wait_report(2, lat);
        chk("ovf_latency", 2, 32'(lat), 32'd3);
`ifdef HEALTH_ACC_SATURATE_EN
        chk("ovf_sum",   2, 32'(out_sum[2]),   32'd255);
        chk("ovf_alarm", 2, 32'(out_alarm[2]), 32'd1);
`else
        chk("ovf_sum",   2, 32'(out_sum[2]),   32'd44);
        chk("ovf_alarm", 2, 32'(out_alarm[2]), 32'd1);
`endif
        release_report(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
